seq_nibble_multiplier: RTL and testbench
========================================

// Module: seq_nibble_multiplier
// PURPOSE
//   Multi-cycle sequencer that computes a (4*N_DIGITS)x(4*N_DIGITS) unsigned product.
//   It reuses a single instance of the 4x4 combinational core top_array_multiplier
//   (ports: product[7:0], A[3:0], B[3:0]).
//   Each cycle, an FSM steps through every pair of operand nibbles. The 8-bit partial
//   product is shifted and added into an accumulator.
//   Operands enter through a valid/ready input handshake; the result leaves through a
//   valid/ready output handshake.
//   Sits between the operand source and the result consumer wherever a wide multiply is
//   needed but only one 4x4 array core is budgeted.
// PARAMETERS
//   N_DIGITS  2  operand width in nibbles; W = 4*N_DIGITS; legal range 1..4
// PORTS
//   clk        in   1    single clock, all state updates on rising edge
//   rst        in   1    synchronous, active-high reset
//   in_valid   in   1    a/b valid this cycle
//   in_ready   out  1    block can accept operands (high only in IDLE)
//   a          in   W    multiplicand, unsigned
//   b          in   W    multiplier, unsigned
//   out_valid  out  1    product valid (high only in DONE)
//   out_ready  in   1    consumer accepts product
//   product    out  2W   unsigned product a*b
//   busy       out  1    high in MUL or DONE
// BEHAVIOUR
//   Reset (rst=1 at an edge)
//   - state=IDLE; in_ready=1; out_valid=0; busy=0; product=0; accumulator=0; i=j=0.
//   - Reset applies in any state. An in-flight multiply is discarded with no output.
//   FSM states: IDLE, MUL, DONE.
//   IDLE
//   - in_ready=1.
//   - At an edge with in_valid=1: register a and b, clear acc, set i=0, j=0, go to MUL.
//   MUL
//   - Core inputs: A = a_reg[4i+3:4i], B = b_reg[4j+3:4j].
//   - At each edge: acc <= acc + (core_product << 4*(i+j)).
//   - j is the inner index. When j=N_DIGITS-1: set j=0 and i=i+1.
//   - At the edge where i=j=N_DIGITS-1, also go to DONE.
//   - Exactly N_DIGITS^2 MUL edges per operation; no early exit for zero operands.
//   DONE
//   - out_valid=1; product = acc.
//   - product holds stable while out_valid=1 and out_ready=0.
//   - At an edge with out_ready=1: go to IDLE. out_valid drops and in_ready rises in the
//     next cycle. No same-cycle turnaround.
//   Latency
//   - Accept at edge T0 -> out_valid first high after edge T0+N_DIGITS^2.
//   - Default: 4 edges.
//   Throughput: one result per N_DIGITS^2+2 cycles minimum.
//   Arithmetic
//   - acc is 2W bits. The sum never overflows, since max = (2^W-1)^2 < 2^(2W).
//   - Shifts are zero-filled.
//   Ignored inputs
//   - in_valid while busy: ignored; operands are not latched.
//   - a/b changes during MUL: no effect.
//   - out_ready outside DONE: ignored.
//   Outputs
//   - in_ready, out_valid and busy are decoded from the registered state.
//   - product is registered acc, held across the return to IDLE until the next accept
//     clears it.
// TESTING
//   1. rst=1 for 2 cycles -> in_ready=1, out_valid=0, busy=0, product=0.
//   2. a=8'hFF, b=8'hFF accepted at T0, out_ready=1
//      -> out_valid high after edge T0+4 with product=16'hFE01, then IDLE.
//   3. a=8'h00, b=8'hA5 -> product=16'h0000, still 4-edge latency;
//      a=8'h12, b=8'h34 -> 16'h03A8.
//   4. a=8'h9C, b=8'h37 with out_ready=0 for 5 cycles -> product=16'h2184 held,
//      out_valid stays 1; in_valid pulses during MUL/DONE are ignored.
//   5. rst=1 at the 2nd MUL edge -> next cycle IDLE, in_ready=1, product=0.
//      The following op a=8'h0F, b=8'h10 yields 16'h00F0.
//   6. 1000 random a/b with random in_valid/out_ready gaps, for N_DIGITS=1,2,3
//      -> every product equals a*b, in order, none lost or duplicated.

Source files
------------

// File: rtl/seq_nibble_multiplier.sv
// Wide unsigned multiplier built around one shared 4x4 array core.
// Operands are accepted in IDLE. The FSM then visits every nibble pair (i, j) and
// adds each shifted partial product into a 2W-bit accumulator. The result is
// presented in DONE until the consumer takes it.

// 4x4 unsigned array multiplier core (purely combinational)
module top_array_multiplier (
  output logic [7:0] product,
  input  logic [3:0] A,
  input  logic [3:0] B
);

  // Sum the four AND-gated rows, each shifted by its multiplier bit position
  always_comb begin
    product = '0;
    for (int r = 0; r < 4; r++) begin
      product = product + ({4'b0000, A & {4{B[r]}}} << r);
    end
  end

endmodule

module seq_nibble_multiplier #(
  parameter int N_DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*N_DIGITS-1:0] a,
  input  logic [4*N_DIGITS-1:0] b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*N_DIGITS-1:0] product,
  output logic                  busy
);

  localparam int W = 4 * N_DIGITS;
  localparam logic [1:0] LAST_IDX = 2'(N_DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [2*W-1:0] acc_q;
  logic [1:0]     i_q;
  logic [1:0]     j_q;
  logic           in_ready_q;
  logic           out_valid_q;
  logic           busy_q;

  logic [3:0]     coreA;
  logic [3:0]     coreB;
  logic [7:0]     coreProduct;
  logic [4:0]     shiftAmt;
  logic [2*W-1:0] acc_d;

  // Select the current nibble pair and form the accumulator update
  always_comb begin
    coreA    = 4'(a_q >> {i_q, 2'b00});
    coreB    = 4'(b_q >> {j_q, 2'b00});
    shiftAmt = {1'b0, i_q, 2'b00} + {1'b0, j_q, 2'b00};
    acc_d    = acc_q + ((2*W)'(coreProduct) << shiftAmt);
  end

  top_array_multiplier u_core (
    .product (coreProduct),
    .A       (coreA),
    .B       (coreB)
  );

  // Control FSM with registered handshake flags, operand latches and accumulator
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      i_q         <= '0;
      j_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= a;
            b_q        <= b;
            acc_q      <= '0;
            i_q        <= '0;
            j_q        <= '0;
            state_q    <= MUL;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        MUL: begin
          acc_q <= acc_d;
          if (j_q == LAST_IDX) begin
            j_q <= '0;
            if (i_q == LAST_IDX) begin
              i_q         <= '0;
              state_q     <= DONE;
              out_valid_q <= 1'b1;
            end else begin
              i_q <= i_q + 2'd1;
            end
          end else begin
            j_q <= j_q + 2'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign product   = acc_q;

endmodule

// File: tb/tb_seq_nibble_multiplier.sv
// Testbench for seq_nibble_multiplier.
// Directed scenarios run on an N_DIGITS=2 instance. Randomised traffic then runs
// on N_DIGITS=1,2,3 instances against a queue-based reference of a*b.

module tb_seq_nibble_multiplier;

  logic        clk;
  logic        rst;
  logic        inValid;
  logic        inReady;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        outValid;
  logic        outReady;
  logic [15:0] product;
  logic        busy;

  int compareCount  = 0;
  int mismatchCount = 0;
  int doneCnt       = 0;
  logic startRandom = 1'b0;

  seq_nibble_multiplier #(.N_DIGITS(2)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .a         (a),
    .b         (b),
    .out_valid (outValid),
    .out_ready (outReady),
    .product   (product),
    .busy      (busy)
  );

  // Free-running clock shared by every instance
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One full operation on the N=2 instance with latency, hold and return checks
  task automatic applyStimulus(input logic [7:0] opA, input logic [7:0] opB,
                               input logic [15:0] expP, input int holdCycles,
                               input string tag);
    @(negedge clk);
    a        = opA;
    b        = opB;
    inValid  = 1'b1;
    outReady = (holdCycles == 0);
    @(posedge clk);
    @(negedge clk);
    checkOutput({tag, "_busy"}, 64'(busy), 64'd1);
    checkOutput({tag, "_inReadyLow"}, 64'(inReady), 64'd0);
    if (holdCycles > 0) begin
      inValid = 1'b1;
      a       = 8'h11;
      b       = 8'h11;
    end else begin
      inValid = 1'b0;
    end
    for (int k = 1; k < 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput({tag, "_earlyValid"}, 64'(outValid), 64'd0);
    end
    @(posedge clk);
    @(negedge clk);
    checkOutput({tag, "_outValid"}, 64'(outValid), 64'd1);
    checkOutput({tag, "_product"}, 64'(product), 64'(expP));
    for (int h = 0; h < holdCycles; h++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput({tag, "_holdValid"}, 64'(outValid), 64'd1);
      checkOutput({tag, "_holdProduct"}, 64'(product), 64'(expP));
      checkOutput({tag, "_holdInReady"}, 64'(inReady), 64'd0);
    end
    inValid  = 1'b0;
    outReady = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput({tag, "_idleValid"}, 64'(outValid), 64'd0);
    checkOutput({tag, "_idleInReady"}, 64'(inReady), 64'd1);
    checkOutput({tag, "_idleBusy"}, 64'(busy), 64'd0);
    checkOutput({tag, "_idleProduct"}, 64'(product), 64'(expP));
    outReady = 1'b0;
  endtask

  // Randomised traffic per width, scored against a queue of a*b values
  for (genvar k = 0; k < 3; k++) begin : gRand
    localparam int N = k + 1;
    localparam int W = 4 * N;

    logic           rValid;
    logic           rInReady;
    logic [W-1:0]   rA;
    logic [W-1:0]   rB;
    logic           rOutValid;
    logic           rOutReady;
    logic [2*W-1:0] rProd;
    logic           rBusy;

    seq_nibble_multiplier #(.N_DIGITS(N)) u_rand (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (rValid),
      .in_ready  (rInReady),
      .a         (rA),
      .b         (rB),
      .out_valid (rOutValid),
      .out_ready (rOutReady),
      .product   (rProd),
      .busy      (rBusy)
    );

    // Producer and consumer decide at the falling edge; handshakes land on the next rising edge
    initial begin
      logic [63:0] expQ[$];
      int accepted;
      int delivered;
      int cycles;
      accepted  = 0;
      delivered = 0;
      cycles    = 0;
      rValid    = 1'b0;
      rOutReady = 1'b0;
      rA        = '0;
      rB        = '0;
      while (!startRandom) @(negedge clk);
      while ((accepted < 1000 || delivered < accepted) && cycles < 60000) begin
        @(negedge clk);
        cycles++;
        rValid = (accepted < 1000) && ($urandom_range(0, 3) != 0);
        rA     = W'($urandom);
        rB     = W'($urandom);
        if (rValid && rInReady) begin
          expQ.push_back(64'(rA) * 64'(rB));
          accepted++;
        end
        rOutReady = ($urandom_range(0, 1) == 1);
        if (rOutValid && rOutReady) begin
          checkOutput($sformatf("N%0d_resultExpected", N), 64'(expQ.size() > 0), 64'd1);
          if (expQ.size() > 0) begin
            checkOutput($sformatf("N%0d_product", N), 64'(rProd), expQ.pop_front());
          end
          delivered++;
        end
      end
      @(negedge clk);
      rValid    = 1'b0;
      rOutReady = 1'b0;
      checkOutput($sformatf("N%0d_inTime", N), 64'(cycles < 60000), 64'd1);
      checkOutput($sformatf("N%0d_delivered", N), 64'(delivered), 64'd1000);
      checkOutput($sformatf("N%0d_leftover", N), 64'(expQ.size()), 64'd0);
      doneCnt++;
    end
  end

  // Directed scenarios, then release the random phase and wait for it
  initial begin
    int waited;
    rst      = 1'b1;
    inValid  = 1'b0;
    outReady = 1'b0;
    a        = '0;
    b        = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_inReady", 64'(inReady), 64'd1);
    checkOutput("rst_outValid", 64'(outValid), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_product", 64'(product), 64'd0);
    rst = 1'b0;

    applyStimulus(8'hFF, 8'hFF, 16'hFE01, 0, "ffxff");
    applyStimulus(8'h00, 8'hA5, 16'h0000, 0, "zeroA");
    applyStimulus(8'h12, 8'h34, 16'h03A8, 0, "t12x34");
    applyStimulus(8'h9C, 8'h37, 16'h2184, 5, "hold");

    @(negedge clk);
    a       = 8'hEE;
    b       = 8'hDD;
    inValid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    inValid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("midRst_inReady", 64'(inReady), 64'd1);
    checkOutput("midRst_busy", 64'(busy), 64'd0);
    checkOutput("midRst_outValid", 64'(outValid), 64'd0);
    checkOutput("midRst_product", 64'(product), 64'd0);
    rst = 1'b0;
    applyStimulus(8'h0F, 8'h10, 16'h00F0, 0, "afterRst");

    startRandom = 1'b1;
    waited = 0;
    while (doneCnt < 3 && waited < 70000) begin
      @(posedge clk);
      waited++;
    end
    checkOutput("randPhaseDone", 64'(doneCnt), 64'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
